// File: rtl/passcode_entry_buffer.sv
// Purpose: keypad passcode buffer with backspace, compare-on-enter, fail lockout and code programming.
// Latency: every input pulse takes effect on the registered outputs one clk after it is sampled.
// Backpressure: none; pushes into a full buffer are dropped, inputs in LOCKED (except clear) ignored.
//
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   digit, valid         keypad digit and its 1-cycle push strobe
//   backspace, clear     remove newest digit / empty the buffer (1-cycle pulses)
//   enter                submit buffer (compare in ENTRY, store code in PROG)
//   prog_req             program-mode request pulse ("program" itself is a reserved word)
//   digits               DEPTH slots of {valid, digit}, slot 0 (first entered) in the MSBs
//   count, full, empty   buffer occupancy
//   match, fail          1-cycle compare result pulses
//   prog_done            1-cycle pulse when the stored code is replaced
//   unlocked, locked     status levels
//   prog_mode            level, high while in PROG
module passcode_entry_buffer #(
  parameter int                         DEPTH        = 4,
  parameter int                         DIGIT_W      = 4,
  parameter logic [DEPTH*DIGIT_W-1:0]   DEFAULT_CODE = 16'h1234,
  parameter int                         MAX_FAILS    = 3,
  parameter int                         LOCK_CYCLES  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DIGIT_W-1:0]               digit,
  input  logic                             valid,
  input  logic                             backspace,
  input  logic                             clear,
  input  logic                             enter,
  input  logic                             prog_req,
  output logic [DEPTH*(DIGIT_W+1)-1:0]     digits,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             full,
  output logic                             empty,
  output logic                             match,
  output logic                             fail,
  output logic                             unlocked,
  output logic                             locked,
  output logic                             prog_mode,
  output logic                             prog_done
);

  localparam int SW = DIGIT_W + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {ST_ENTRY, ST_PROG, ST_LOCKED} state_t;

  state_t                       state;
  logic [DEPTH*SW-1:0]          slots_q;
  logic [CW-1:0]                count_q;
  logic [DEPTH*DIGIT_W-1:0]     code_q;
  logic [DEPTH*DIGIT_W-1:0]     entry_field;
  logic [FW-1:0]                fail_cnt;
  logic [TW-1:0]                timer;

  // Digit field of the buffer with the valid bits stripped; slots beyond
  // count are zero, but comparisons only use this when the buffer is full.
  always_comb begin
    entry_field = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_field[(DEPTH-1-i)*DIGIT_W +: DIGIT_W] = slots_q[(DEPTH-1-i)*SW +: DIGIT_W];
    end
  end

  assign digits    = slots_q;
  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign locked    = (state == ST_LOCKED);
  assign prog_mode = (state == ST_PROG);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_ENTRY;
      slots_q   <= '0;
      count_q   <= '0;
      code_q    <= DEFAULT_CODE;
      fail_cnt  <= '0;
      timer     <= '0;
      match     <= 1'b0;
      fail      <= 1'b0;
      prog_done <= 1'b0;
      unlocked  <= 1'b0;
    end else begin
      match     <= 1'b0;
      fail      <= 1'b0;
      prog_done <= 1'b0;

      // Lockout runs independently of the buffer inputs; timer==1 is the
      // last locked cycle so locked stays high exactly LOCK_CYCLES cycles.
      if (state == ST_LOCKED) begin
        timer <= timer - TW'(1);
        if (timer == TW'(1)) state <= ST_ENTRY;
      end

      if (clear) begin
        slots_q  <= '0;
        count_q  <= '0;
        unlocked <= 1'b0;
        if (state == ST_PROG) state <= ST_ENTRY;
      end else if (state != ST_LOCKED) begin
        if (enter) begin
          if (state == ST_ENTRY) begin
            slots_q <= '0;
            count_q <= '0;
            if (full && entry_field == code_q) begin
              match    <= 1'b1;
              unlocked <= 1'b1;
              fail_cnt <= '0;
            end else begin
              fail <= 1'b1;
              if (fail_cnt == FW'(MAX_FAILS - 1)) begin
                fail_cnt <= '0;
                timer    <= TW'(LOCK_CYCLES);
                state    <= ST_LOCKED;
              end else begin
                fail_cnt <= fail_cnt + FW'(1);
              end
            end
          end else if (full) begin
            // PROG: commit only a complete entry, otherwise keep typing.
            code_q    <= entry_field;
            prog_done <= 1'b1;
            slots_q   <= '0;
            count_q   <= '0;
            state     <= ST_ENTRY;
          end
        end else if (backspace) begin
          if (!empty) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (CW'(i) == count_q - CW'(1)) slots_q[(DEPTH-1-i)*SW +: SW] <= '0;
            end
            count_q <= count_q - CW'(1);
          end
        end else if (valid) begin
          unlocked <= 1'b0;
          if (!full) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (CW'(i) == count_q) slots_q[(DEPTH-1-i)*SW +: SW] <= {1'b1, digit};
            end
            count_q <= count_q + CW'(1);
          end
        end else if (prog_req && state == ST_ENTRY && unlocked) begin
          state    <= ST_PROG;
          slots_q  <= '0;
          count_q  <= '0;
          unlocked <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_passcode_entry_buffer.sv
// Purpose: self-checking bench for passcode_entry_buffer (DEPTH=4, 4-bit digits, code 1234).
// Latency: each vector is driven on the falling edge and checked 1 time unit after the next rising edge.
// Backpressure: not applicable; expected outputs are queued when driven and popped when checked.
module tb_passcode_entry_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  digit;
  logic        valid, backspace, clear, enter, prog_req;
  logic [19:0] digits;
  logic [2:0]  count;
  logic        full, empty, match, fail, unlocked, locked, prog_mode, prog_done;

  passcode_entry_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .digit     (digit),
    .valid     (valid),
    .backspace (backspace),
    .clear     (clear),
    .enter     (enter),
    .prog_req  (prog_req),
    .digits    (digits),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .match     (match),
    .fail      (fail),
    .unlocked  (unlocked),
    .locked    (locked),
    .prog_mode (prog_mode),
    .prog_done (prog_done)
  );

  always #5 clk = ~clk;

  // ctl = {rst, clr, ent, bs, vld, prg}
  localparam logic [5:0] N = 6'b000000, R = 6'b100000, C = 6'b010000, E = 6'b001000,
                         B = 6'b000100, V = 6'b000010, P = 6'b000001;
  // flg = {match, fail, unlocked, locked, prog_mode, prog_done}
  localparam logic [5:0] F0 = 6'b000000, FM = 6'b100000, FF = 6'b010000, FU = 6'b001000,
                         FL = 6'b000100, FP = 6'b000010, FD = 6'b000001;

  typedef struct {
    logic [3:0]  dig;
    logic [5:0]  ctl;
    logic [2:0]  cnt;   // expected count
    logic [15:0] nib;   // expected digits of valid slots, slot 0 in MSBs
    logic [5:0]  flg;   // expected pulses/levels
  } vec_t;

  typedef struct packed {
    logic [19:0] digits;
    logic [2:0]  count;
    logic        full, empty, match, fail, unlocked, locked, prog_mode, prog_done;
  } out_t;

  vec_t vecs[$];
  out_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic out_t mk(input logic [2:0] cnt, input logic [15:0] nib, input logic [5:0] flg);
    out_t o;
    o.digits = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(cnt)) o.digits[(3-i)*5 +: 5] = {1'b1, nib[(3-i)*4 +: 4]};
    end
    o.count = cnt;
    o.full  = (cnt == 3'd4);
    o.empty = (cnt == 3'd0);
    {o.match, o.fail, o.unlocked, o.locked, o.prog_mode, o.prog_done} = flg;
    return o;
  endfunction

  function automatic vec_t mkv(input logic [3:0] d, input logic [5:0] c, input logic [2:0] n,
                               input logic [15:0] nb, input logic [5:0] f);
    vec_t v;
    v.dig = d; v.ctl = c; v.cnt = n; v.nib = nb; v.flg = f;
    return v;
  endfunction

  task automatic add(input logic [3:0] d, input logic [5:0] c, input logic [2:0] n,
                     input logic [15:0] nb, input logic [5:0] f);
    vecs.push_back(mkv(d, c, n, nb, f));
  endtask

  task automatic apply(input vec_t v, input string tag);
    out_t got, want;
    @(negedge clk);
    reset     = ~v.ctl[5];
    clear     = v.ctl[4];
    enter     = v.ctl[3];
    backspace = v.ctl[2];
    valid     = v.ctl[1];
    prog_req  = v.ctl[0];
    digit     = v.dig;
    exp_q.push_back(mk(v.cnt, v.nib, v.flg));
    @(posedge clk);
    #1;
    got  = {digits, count, full, empty, match, fail, unlocked, locked, prog_mode, prog_done};
    want = exp_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got digits=%b count=%0d full=%b empty=%b m/f/u/l/p/d=%b, want digits=%b count=%0d full=%b empty=%b m/f/u/l/p/d=%b",
               tag, got.digits, got.count, got.full, got.empty,
               {got.match, got.fail, got.unlocked, got.locked, got.prog_mode, got.prog_done},
               want.digits, want.count, want.full, want.empty,
               {want.match, want.fail, want.unlocked, want.locked, want.prog_mode, want.prog_done});
    end
  endtask

  task automatic go(input logic [3:0] d, input logic [5:0] c, input logic [2:0] n,
                    input logic [15:0] nb, input logic [5:0] f, input string tag);
    apply(mkv(d, c, n, nb, f), tag);
  endtask

  initial begin
    logic [5:0] lock_ctl [5];
    reset = 1'b0; digit = '0; valid = 0; backspace = 0; clear = 0; enter = 0; prog_req = 0;

    // ---- table: push/drop/backspace, match, programming, clear corners ----
    add(0, R, 0, 16'h0000, F0);           // reset state
    add(0, N, 0, 16'h0000, F0);
    add(1, V, 1, 16'h1000, F0);
    add(2, V, 2, 16'h1200, F0);
    add(3, V, 3, 16'h1230, F0);
    add(4, V, 4, 16'h1234, F0);           // full: 10001_10010_10011_10100
    add(5, V, 4, 16'h1234, F0);           // dropped when full
    add(0, B, 3, 16'h1230, F0);
    add(0, B, 2, 16'h1200, F0);
    add(0, B, 1, 16'h1000, F0);
    add(0, B, 0, 16'h0000, F0);
    add(0, B, 0, 16'h0000, F0);           // no underflow
    add(0, B, 0, 16'h0000, F0);
    add(1, V, 1, 16'h1000, F0);
    add(2, V, 2, 16'h1200, F0);
    add(3, V, 3, 16'h1230, F0);
    add(4, V, 4, 16'h1234, F0);
    add(0, E, 0, 16'h0000, FM | FU);      // match, buffer emptied
    add(0, N, 0, 16'h0000, FU);           // match lasts one cycle
    add(9, V, 1, 16'h9000, F0);           // push clears unlocked
    add(0, C, 0, 16'h0000, F0);
    add(1, V, 1, 16'h1000, F0);
    add(2, V, 2, 16'h1200, F0);
    add(3, V, 3, 16'h1230, F0);
    add(4, V, 4, 16'h1234, F0);
    add(0, E, 0, 16'h0000, FM | FU);
    add(0, P, 0, 16'h0000, FP);           // enter program mode
    add(0, P, 0, 16'h0000, FP);           // program ignored in PROG
    add(5, V, 1, 16'h5000, FP);
    add(6, V, 2, 16'h5600, FP);
    add(7, V, 3, 16'h5670, FP);
    add(0, E, 3, 16'h5670, FP);           // incomplete: ignored, kept
    add(8, V, 4, 16'h5678, FP);
    add(0, E, 0, 16'h0000, FD);           // code replaced
    add(0, N, 0, 16'h0000, F0);
    add(1, V, 1, 16'h1000, F0);
    add(2, V, 2, 16'h1200, F0);
    add(3, V, 3, 16'h1230, F0);
    add(4, V, 4, 16'h1234, F0);
    add(0, E, 0, 16'h0000, FF);           // old code now fails
    add(5, V, 1, 16'h5000, F0);
    add(6, V, 2, 16'h5600, F0);
    add(7, V, 3, 16'h5670, F0);
    add(8, V, 4, 16'h5678, F0);
    add(0, E, 0, 16'h0000, FM | FU);      // new code matches
    add(3, C | V, 0, 16'h0000, F0);       // clear beats valid, clears unlocked
    add(5, V, 1, 16'h5000, F0);
    add(6, V, 2, 16'h5600, F0);
    add(7, V, 3, 16'h5670, F0);
    add(8, V, 4, 16'h5678, F0);
    add(0, E, 0, 16'h0000, FM | FU);
    add(0, P, 0, 16'h0000, FP);
    add(1, V, 1, 16'h1000, FP);
    add(0, C, 0, 16'h0000, F0);           // abort PROG, no prog_done
    add(1, V, 1, 16'h1000, F0);           // back in ENTRY
    add(0, C, 0, 16'h0000, F0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // ---- lockout: reset restores 1234, three fails, 16 locked cycles ----
    go(0, R, 0, 16'h0000, F0, "rst_code");
    go(1, V, 1, 16'h1000, F0, "lk_a1");
    go(2, V, 2, 16'h1200, F0, "lk_a2");
    go(3, V, 3, 16'h1230, F0, "lk_a3");
    go(0, E, 0, 16'h0000, FF, "lk_fail1");
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++)
        go(9, V, 3'(k + 1), (16'h9999 >> (4 * (3 - k))) << (4 * (3 - k)), F0, "lk_push9");
      if (r == 0) go(0, E, 0, 16'h0000, FF, "lk_fail2");
      else        go(0, E, 0, 16'h0000, FF | FL, "lk_fail3");
    end
    lock_ctl[0] = V; lock_ctl[1] = E; lock_ctl[2] = P; lock_ctl[3] = B; lock_ctl[4] = C;
    for (int k = 0; k < 15; k++) go(1, lock_ctl[k % 5], 0, 16'h0000, FL, $sformatf("lk_hold%0d", k));
    go(0, N, 0, 16'h0000, F0, "lk_release");
    go(1, V, 1, 16'h1000, F0, "ul_1");
    go(2, V, 2, 16'h1200, F0, "ul_2");
    go(3, V, 3, 16'h1230, F0, "ul_3");
    go(4, V, 4, 16'h1234, F0, "ul_4");
    go(0, E, 0, 16'h0000, FM | FU, "ul_match");

    // ---- reset during PROG and during LOCKED ----
    go(0, P, 0, 16'h0000, FP, "rp_prog");
    go(5, V, 1, 16'h5000, FP, "rp_push");
    go(0, R | E, 0, 16'h0000, F0, "rp_reset");
    go(0, N, 0, 16'h0000, F0, "rp_idle");
    go(0, E, 0, 16'h0000, FF, "rl_f1");
    go(0, E, 0, 16'h0000, FF, "rl_f2");
    go(0, E, 0, 16'h0000, FF | FL, "rl_f3");
    go(0, N, 0, 16'h0000, FL, "rl_hold");
    go(0, R, 0, 16'h0000, F0, "rl_reset");
    go(0, N, 0, 16'h0000, F0, "rl_idle");
    go(1, V, 1, 16'h1000, F0, "rl_1");
    go(2, V, 2, 16'h1200, F0, "rl_2");
    go(3, V, 3, 16'h1230, F0, "rl_3");
    go(4, V, 4, 16'h1234, F0, "rl_4");
    go(0, E, 0, 16'h0000, FM | FU, "rl_match");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
